pdm_tx: RTL

Single-channel PCM-to-PDM transmitter. It is the transmit-side counterpart of the PDM-microphone CIC decimator path, and drives a PDM DAC, amplifier or loopback line. It accepts 16-bit signed PCM samples through a valid/ready handshake into a 2-entry buffer. Each sample is held for OSR PDM bit periods and converted to a 1-bit stream by a second-order sigma-delta modulator. The block generates its own PDM bit clock from the system clock.

---
 rtl/pdm_pkg.sv | 38 +++
 rtl/pdm_sd2.sv | 77 +++++++
 rtl/pdm_tx.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pdm_pkg.sv
// pdm_pkg: shared constants and saturation helper for the PDM transmit and
// decimator paths. The modulator's optional dither is enabled by defining
// PDM_TX_DITHER_EN (see pdm_sd2).
package pdm_pkg;

  localparam int PCM_W        = 16;
  localparam int DEF_OSR      = 64;
  localparam int DEF_HALF_DIV = 6;
  localparam int DEF_ACC_W    = 24;

  // Feedback levels the modulator subtracts for a 1 / 0 output bit.
  localparam int FB_POS = 32'sd32767;
  localparam int FB_NEG = -32'sd32768;

  // Working width for integrator arithmetic; wide enough that no sum of an
  // ACC_W value and two PCM-range terms can overflow before clamping.
  localparam int SAT_W = 40;
  localparam logic signed [SAT_W-1:0] SAT_ONE = 40'sd1;

  // Clamp v to the signed range of a w-bit accumulator (never wraps).
  function automatic logic signed [SAT_W-1:0] sat_acc(
    input logic signed [SAT_W-1:0] v,
    input int                      w
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_ONE <<< (w - 1)) - SAT_ONE;
    lo = -hi - SAT_ONE;
    if (v > hi) begin
      sat_acc = hi;
    end else if (v < lo) begin
      sat_acc = lo;
    end else begin
      sat_acc = v;
    end
  endfunction

endpackage

// File: rtl/pdm_sd2.sv
// pdm_sd2: second-order saturating sigma-delta modulator core. Advances one
// step per tick. Define PDM_TX_DITHER_EN to add a 2-bit LFSR dither to x.
module pdm_sd2
  import pdm_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic signed [PCM_W-1:0] x,
  output logic                    bit_out
);

  localparam int EXT_W = SAT_W - ACC_W;

  logic signed [ACC_W-1:0] i1_r;
  logic signed [ACC_W-1:0] i2_r;
  logic                    bit_r;

  logic signed [SAT_W-1:0] x_s;
  logic signed [SAT_W-1:0] y_s;
  logic signed [SAT_W-1:0] i1_sat_s;
  logic signed [SAT_W-1:0] i2_sat_s;

`ifdef PDM_TX_DITHER_EN
  logic [15:0] lfsr_r;

  // Galois LFSR stepping once per bit tick to decorrelate idle tones.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr_r <= 16'hACE1;
    end else if (tick) begin
      lfsr_r <= {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? 16'hB400 : 16'h0000);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  // Input term: sample plus signed dither in -2..+1.
  always_comb begin
    x_s = {{(SAT_W-PCM_W){x[PCM_W-1]}}, x} + {{(SAT_W-2){lfsr_r[1]}}, lfsr_r[1:0]};
  end
`else
  // Input term: sample used unmodified.
  always_comb begin
    x_s = {{(SAT_W-PCM_W){x[PCM_W-1]}}, x};
  end
`endif

  // Next integrator values from the current output bit's feedback level.
  always_comb begin
    y_s      = bit_r ? SAT_W'(FB_POS) : SAT_W'(FB_NEG);
    i1_sat_s = sat_acc({{EXT_W{i1_r[ACC_W-1]}}, i1_r} + x_s - y_s, ACC_W);
    i2_sat_s = sat_acc({{EXT_W{i2_r[ACC_W-1]}}, i2_r} + i1_sat_s - y_s, ACC_W);
  end

  // Integrators and quantiser output, updated only on bit ticks.
  always_ff @(posedge clk) begin
    if (!reset) begin
      i1_r  <= {ACC_W{1'b0}};
      i2_r  <= {ACC_W{1'b0}};
      bit_r <= 1'b0;
    end else if (tick) begin
      i1_r  <= i1_sat_s[ACC_W-1:0];
      i2_r  <= i2_sat_s[ACC_W-1:0];
      bit_r <= ~i2_sat_s[ACC_W-1];
    end else begin
      i1_r  <= i1_r;
      i2_r  <= i2_r;
      bit_r <= bit_r;
    end
  end

  assign bit_out = bit_r;

endmodule

// File: rtl/pdm_tx.sv
// pdm_tx: PCM-to-PDM transmitter. 2-entry sample buffer, PDM clock divider,
// OSR-bit sample sequencing and a pdm_sd2 modulator core. Optional dither in
// the core is enabled with PDM_TX_DITHER_EN.
module pdm_tx
  import pdm_pkg::*;
#(
  parameter int HALF_DIV = DEF_HALF_DIV,
  parameter int OSR      = DEF_OSR,
  parameter int ACC_W    = DEF_ACC_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [PCM_W-1:0] pcm_in,
  input  logic                    pcm_valid,
  output logic                    pcm_ready,
  output logic                    pdm_clk,
  output logic                    pdm_out,
  output logic                    underrun,
  output logic                    sample_strobe
);

  localparam int DIV_W = $clog2(HALF_DIV);
  localparam int BIT_W = $clog2(OSR);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(OSR - 1);

  logic [DIV_W-1:0]        div_cnt_r;
  logic                    pdm_clk_r;
  logic [BIT_W-1:0]        bit_cnt_r;
  logic signed [PCM_W-1:0] mem_r [2];
  logic                    wr_ptr_r;
  logic                    rd_ptr_r;
  logic [1:0]              count_r;
  logic                    ready_r;
  logic signed [PCM_W-1:0] held_r;
  logic                    underrun_r;
  logic                    strobe_r;

  logic                    wrap_s;
  logic                    tick_s;
  logic                    start_s;
  logic                    wr_s;
  logic                    pop_s;
  logic [1:0]              count_next_s;
  logic signed [PCM_W-1:0] x_s;
  logic                    bit_s;

  // A bit tick is the divider wrap that takes pdm_clk from 1 to 0.
  assign wrap_s  = (div_cnt_r == DIV_LAST);
  assign tick_s  = wrap_s & pdm_clk_r;
  assign start_s = tick_s & (bit_cnt_r == {BIT_W{1'b0}});
  assign wr_s    = pcm_valid & ready_r;
  assign pop_s   = start_s & (count_r != 2'd0);

  // PDM clock divider.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt_r <= {DIV_W{1'b0}};
      pdm_clk_r <= 1'b0;
    end else if (wrap_s) begin
      div_cnt_r <= {DIV_W{1'b0}};
      pdm_clk_r <= ~pdm_clk_r;
    end else begin
      div_cnt_r <= div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
      pdm_clk_r <= pdm_clk_r;
    end
  end

  // Buffer occupancy after this cycle's write and/or pop.
  always_comb begin
    count_next_s = count_r;
    case ({wr_s, pop_s})
      2'b10:   count_next_s = count_r + 2'd1;
      2'b01:   count_next_s = count_r - 2'd1;
      default: count_next_s = count_r;
    endcase
  end

  // Two-entry sample FIFO; ready is registered from the next occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_r[0] <= 16'sd0;
      mem_r[1] <= 16'sd0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
      ready_r  <= 1'b1;
    end else begin
      if (wr_s) begin
        mem_r[wr_ptr_r] <= pcm_in;
        wr_ptr_r        <= ~wr_ptr_r;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      rd_ptr_r <= pop_s ? ~rd_ptr_r : rd_ptr_r;
      count_r  <= count_next_s;
      ready_r  <= (count_next_s != 2'd2);
    end
  end

  // The first tick of a period already uses the freshly popped sample.
  always_comb begin
    if (pop_s) begin
      x_s = mem_r[rd_ptr_r];
    end else begin
      x_s = held_r;
    end
  end

  // Bit counter, held sample, sticky underrun and sample strobe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bit_cnt_r  <= {BIT_W{1'b0}};
      held_r     <= 16'sd0;
      underrun_r <= 1'b0;
      strobe_r   <= 1'b0;
    end else begin
      strobe_r <= start_s;
      if (tick_s) begin
        bit_cnt_r <= (bit_cnt_r == BIT_LAST) ? {BIT_W{1'b0}}
                                             : bit_cnt_r + {{(BIT_W-1){1'b0}}, 1'b1};
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
      held_r     <= pop_s ? mem_r[rd_ptr_r] : held_r;
      underrun_r <= underrun_r | (start_s & (count_r == 2'd0));
    end
  end

  pdm_sd2 #(
    .ACC_W (ACC_W)
  ) u_sd2 (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick_s),
    .x       (x_s),
    .bit_out (bit_s)
  );

  assign pcm_ready     = ready_r;
  assign pdm_clk       = pdm_clk_r;
  assign pdm_out       = bit_s;
  assign underrun      = underrun_r;
  assign sample_strobe = strobe_r;

endmodule
